// File: rtl/orbit_phase_lut_if.sv
// Control and result signals of the orbit phase generator.
// The master drives the phase controls; the slave (the generator) returns the sin/cos pair.
`timescale 1ns/1ps

interface orbit_phase_lut_if #(
  parameter int unsigned PHASE_W = 16
);
  logic                enable;
  logic [PHASE_W-1:0]  step_in;
  logic                dir;
  logic                phase_load;
  logic [PHASE_W-1:0]  phase_init;
  logic [PHASE_W-1:0]  phase_out;
  logic signed [15:0]  sin_out;
  logic signed [15:0]  cos_out;
  logic                valid;
  logic                busy;

  modport master (
    output enable, step_in, dir, phase_load, phase_init,
    input  phase_out, sin_out, cos_out, valid, busy
  );

  modport slave (
    input  enable, step_in, dir, phase_load, phase_init,
    output phase_out, sin_out, cos_out, valid, busy
  );
endinterface

// File: rtl/orbit_phase_lut.sv
// Clock-divided phase accumulator feeding a shared quarter-wave sine ROM; emits a signed
// sin/cos pair with a one-cycle valid strobe for the orbital motion stage.
`timescale 1ns/1ps

module orbit_phase_lut #(
  parameter int unsigned CLK_DIV = 500000,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned AMP     = 16384
) (
  input  logic              clk,
  input  logic              reset_n,
  orbit_phase_lut_if.slave  bus
);

  localparam int unsigned N    = 2 ** LUT_AW;
  localparam int unsigned CntW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    StIdle,
    StSinA,
    StSinD,
    StCosA,
    StCosD,
    StDone
  } state_e;

  // Quarter-wave table evaluated at elaboration: round(AMP * sin(pi/2 * k / N)).
  function automatic logic [15:0] rom_entry(input int unsigned k);
    real a;
    a = real'(AMP) * $sin(3.141592653589793 / 2.0 * real'(k) / real'(N));
    return 16'($rtoi(a + 0.5));
  endfunction

  logic [15:0] rom_table [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    assign rom_table[k] = rom_entry(k);
  end

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] p_q, p_d;
  logic [15:0]        rom_q;
  logic [15:0]        sin_stage_q, sin_stage_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        sin_q, sin_d;
  logic [15:0]        cos_q, cos_d;

  logic               tick;
  logic               start;
  logic [PHASE_W-1:0] p_sel;
  logic [1:0]         q_sel;
  logic [LUT_AW-1:0]  idx;
  logic [LUT_AW-1:0]  rom_addr;
  logic               full_scale;
  logic [15:0]        mag;
  logic [15:0]        lut_val;

  assign tick  = bus.enable && (cnt_q == CntW'(CLK_DIV - 1));
  assign start = tick && (state_q == StIdle);
  assign p_sel = bus.phase_load ? bus.phase_init : acc_q;
  assign idx   = p_q[PHASE_W-3 -: LUT_AW];

  // Cosine is the sine of the next quadrant at the same index.
  always_comb begin
    q_sel = p_q[PHASE_W-1 -: 2];
    if (state_q == StCosA || state_q == StCosD) begin
      q_sel = p_q[PHASE_W-1 -: 2] + 2'd1;
    end
    full_scale = q_sel[0] && (idx == '0);
    rom_addr   = q_sel[0] ? (LUT_AW'(0) - idx) : idx;
    mag        = full_scale ? 16'(AMP) : rom_q;
    lut_val    = q_sel[1] ? (16'd0 - mag) : mag;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    p_d         = p_q;
    sin_stage_d = sin_stage_q;
    phase_d     = phase_q;
    sin_d       = sin_q;
    cos_d       = cos_q;

    if (bus.enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    if (start) begin
      p_d   = p_sel;
      acc_d = bus.dir ? (p_sel - bus.step_in) : (p_sel + bus.step_in);
    end else if (bus.phase_load) begin
      acc_d = bus.phase_init;
    end

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StSinA;
      end
      StSinA: state_d = StSinD;
      StSinD: begin
        sin_stage_d = lut_val;
        state_d     = StCosA;
      end
      StCosA: state_d = StCosD;
      StCosD: begin
        phase_d = p_q;
        sin_d   = sin_stage_q;
        cos_d   = lut_val;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      rom_q       <= '0;
      sin_stage_q <= '0;
      phase_q     <= '0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      rom_q       <= rom_table[rom_addr];
      sin_stage_q <= sin_stage_d;
      phase_q     <= phase_d;
      sin_q       <= sin_d;
      cos_q       <= cos_d;
    end
  end

  assign bus.phase_out = phase_q;
  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.valid     = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);

endmodule
